// File: rtl/pong_match_ctrl.sv
// pong_match_ctrl
// Match sequencer for Pong. Runs the IDLE/SERVE/PLAY/OVER match FSM, keeps
// both score counters, drives the ball reset/enable and gameover controls,
// and turns held paddle buttons into rate-limited one-cycle move pulses.
//
// State table:
//   state   | meaning
//   IDLE    | waiting for the first start press, ball held at centre
//   SERVE   | ball held at centre for SERVE_DELAY frame ticks
//   PLAY    | ball moving, goals are scored
//   OVER    | a player reached WIN_SCORE, ball frozen, waiting for start
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   frame_tick                 one-cycle pulse per video frame
//   start                      start button level (already synchronised)
//   p1/p2_up_btn, _dn_btn      paddle button levels
//   goal_p1, goal_p2           point to player 1 / player 2
//   p1/p2_up, p1/p2_down       one-cycle paddle move pulses
//   ball_rst, ball_en          ball hold-at-centre and motion enable
//   serve_dir                  0 = toward player 1, 1 = toward player 2
//   p1_score, p2_score         current scores
//   gameover, winner           match finished, winning player (0 = p1)
//   state                      debug view of the FSM state
// All outputs are registered.

module pong_match_ctrl #(
    parameter int WIN_SCORE   = 7,
    parameter int SERVE_DELAY = 60,
    parameter int MOVE_PERIOD = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       start,
    input  logic       p1_up_btn,
    input  logic       p1_dn_btn,
    input  logic       p2_up_btn,
    input  logic       p2_dn_btn,
    input  logic       goal_p1,
    input  logic       goal_p2,
    output logic       p1_up,
    output logic       p1_down,
    output logic       p2_up,
    output logic       p2_down,
    output logic       ball_rst,
    output logic       ball_en,
    output logic       serve_dir,
    output logic [3:0] p1_score,
    output logic [3:0] p2_score,
    output logic       gameover,
    output logic       winner,
    output logic [1:0] state
);

    localparam int SW = $clog2(SERVE_DELAY + 1);
    localparam int MW = (MOVE_PERIOD > 1) ? $clog2(MOVE_PERIOD) : 1;
    localparam logic [SW-1:0] SERVE_LOAD = SW'(SERVE_DELAY);
    localparam logic [MW-1:0] MOVE_LOAD  = MW'(MOVE_PERIOD - 1);
    localparam logic [3:0]    WIN        = 4'(WIN_SCORE);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SERVE = 2'd1,
        S_PLAY  = 2'd2,
        S_OVER  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic          start_q;
    logic [SW-1:0] serve_cnt_q, serve_cnt_d;
    logic [3:0]    p1_score_q, p1_score_d;
    logic [3:0]    p2_score_q, p2_score_d;
    logic          serve_dir_q, serve_dir_d;
    logic          winner_q, winner_d;
    logic          ball_rst_q, ball_rst_d;
    logic          ball_en_q, ball_en_d;
    logic          gameover_q, gameover_d;
    logic [MW-1:0] p1_tmr_q, p1_tmr_d;
    logic [MW-1:0] p2_tmr_q, p2_tmr_d;
    logic          p1_up_q, p1_up_d, p1_dn_q, p1_dn_d;
    logic          p2_up_q, p2_up_d, p2_dn_q, p2_dn_d;

    logic       start_press;
    logic [3:0] p1_inc, p2_inc;
    logic       move_active;

    // start_q resets to 1 so a button held through reset is not a press.
    assign start_press = start & ~start_q;
    assign p1_inc      = p1_score_q + 4'd1;
    assign p2_inc      = p2_score_q + 4'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            start_q     <= 1'b1;
            serve_cnt_q <= '0;
            p1_score_q  <= '0;
            p2_score_q  <= '0;
            serve_dir_q <= 1'b0;
            winner_q    <= 1'b0;
            ball_rst_q  <= 1'b1;
            ball_en_q   <= 1'b0;
            gameover_q  <= 1'b0;
            p1_tmr_q    <= '0;
            p2_tmr_q    <= '0;
            p1_up_q     <= 1'b0;
            p1_dn_q     <= 1'b0;
            p2_up_q     <= 1'b0;
            p2_dn_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            start_q     <= start;
            serve_cnt_q <= serve_cnt_d;
            p1_score_q  <= p1_score_d;
            p2_score_q  <= p2_score_d;
            serve_dir_q <= serve_dir_d;
            winner_q    <= winner_d;
            ball_rst_q  <= ball_rst_d;
            ball_en_q   <= ball_en_d;
            gameover_q  <= gameover_d;
            p1_tmr_q    <= p1_tmr_d;
            p2_tmr_q    <= p2_tmr_d;
            p1_up_q     <= p1_up_d;
            p1_dn_q     <= p1_dn_d;
            p2_up_q     <= p2_up_d;
            p2_dn_q     <= p2_dn_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        serve_cnt_d = serve_cnt_q;
        p1_score_d  = p1_score_q;
        p2_score_d  = p2_score_q;
        serve_dir_d = serve_dir_q;
        winner_d    = winner_q;
        case (state_q)
            S_IDLE: begin
                if (start_press) begin
                    state_d     = S_SERVE;
                    serve_cnt_d = SERVE_LOAD;
                    p1_score_d  = '0;
                    p2_score_d  = '0;
                end
            end
            S_SERVE: begin
                if (frame_tick) begin
                    serve_cnt_d = serve_cnt_q - SW'(1);
                    if (serve_cnt_q == SW'(1)) begin
                        state_d = S_PLAY;
                    end
                end
            end
            S_PLAY: begin
                // goal_p1 has priority; a simultaneous goal_p2 is dropped.
                if (goal_p1) begin
                    p1_score_d  = p1_inc;
                    serve_dir_d = 1'b1;
                    if (p1_inc == WIN) begin
                        state_d  = S_OVER;
                        winner_d = 1'b0;
                    end else begin
                        state_d     = S_SERVE;
                        serve_cnt_d = SERVE_LOAD;
                    end
                end else if (goal_p2) begin
                    p2_score_d  = p2_inc;
                    serve_dir_d = 1'b0;
                    if (p2_inc == WIN) begin
                        state_d  = S_OVER;
                        winner_d = 1'b1;
                    end else begin
                        state_d     = S_SERVE;
                        serve_cnt_d = SERVE_LOAD;
                    end
                end
            end
            S_OVER: begin
                if (start_press) begin
                    state_d     = S_SERVE;
                    serve_cnt_d = SERVE_LOAD;
                    p1_score_d  = '0;
                    p2_score_d  = '0;
                    serve_dir_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Ball/gameover controls are decoded from the next state so they change
    // on the same cycle as the state output.
    always_comb begin
        ball_rst_d = (state_d == S_IDLE) || (state_d == S_SERVE);
        ball_en_d  = (state_d == S_PLAY);
        gameover_d = (state_d == S_OVER);
    end

    // Gating on both current and next state keeps pulses out of the cycles
    // where the state output already shows IDLE or OVER.
    assign move_active = ((state_q == S_SERVE) || (state_q == S_PLAY)) &&
                         ((state_d == S_SERVE) || (state_d == S_PLAY));

    always_comb begin
        p1_tmr_d = p1_tmr_q;
        p1_up_d  = 1'b0;
        p1_dn_d  = 1'b0;
        if (!move_active) begin
            p1_tmr_d = '0;
        end else if (p1_up_btn ^ p1_dn_btn) begin
            if (frame_tick) begin
                if (p1_tmr_q == '0) begin
                    if (!(p1_up_q | p1_dn_q)) begin
                        p1_up_d  = p1_up_btn;
                        p1_dn_d  = p1_dn_btn;
                        p1_tmr_d = MOVE_LOAD;
                    end
                end else begin
                    p1_tmr_d = p1_tmr_q - MW'(1);
                end
            end
        end else begin
            p1_tmr_d = '0;
        end
    end

    always_comb begin
        p2_tmr_d = p2_tmr_q;
        p2_up_d  = 1'b0;
        p2_dn_d  = 1'b0;
        if (!move_active) begin
            p2_tmr_d = '0;
        end else if (p2_up_btn ^ p2_dn_btn) begin
            if (frame_tick) begin
                if (p2_tmr_q == '0) begin
                    if (!(p2_up_q | p2_dn_q)) begin
                        p2_up_d  = p2_up_btn;
                        p2_dn_d  = p2_dn_btn;
                        p2_tmr_d = MOVE_LOAD;
                    end
                end else begin
                    p2_tmr_d = p2_tmr_q - MW'(1);
                end
            end
        end else begin
            p2_tmr_d = '0;
        end
    end

    assign p1_up     = p1_up_q;
    assign p1_down   = p1_dn_q;
    assign p2_up     = p2_up_q;
    assign p2_down   = p2_dn_q;
    assign ball_rst  = ball_rst_q;
    assign ball_en   = ball_en_q;
    assign serve_dir = serve_dir_q;
    assign p1_score  = p1_score_q;
    assign p2_score  = p2_score_q;
    assign gameover  = gameover_q;
    assign winner    = winner_q;
    assign state     = state_q;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Testbench for pong_match_ctrl with WIN_SCORE=3, SERVE_DELAY=3,
// MOVE_PERIOD=2. Each vector drives inputs for one cycle (frame_tick and
// goals only in that cycle), checks every output after the edge, then runs
// `pad` cycles with levels held so ticks land every 10 clk.

module tb_pong_match_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_tick = 1'b0;
    logic       start = 1'b1;
    logic       p1_up_btn = 1'b0, p1_dn_btn = 1'b0;
    logic       p2_up_btn = 1'b0, p2_dn_btn = 1'b0;
    logic       goal_p1 = 1'b0, goal_p2 = 1'b0;
    logic       p1_up, p1_down, p2_up, p2_down;
    logic       ball_rst, ball_en, serve_dir, gameover, winner;
    logic [3:0] p1_score, p2_score;
    logic [1:0] state;

    int n_checks = 0;
    int n_fail   = 0;

    pong_match_ctrl #(
        .WIN_SCORE  (3),
        .SERVE_DELAY(3),
        .MOVE_PERIOD(2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .frame_tick(frame_tick),
        .start     (start),
        .p1_up_btn (p1_up_btn),
        .p1_dn_btn (p1_dn_btn),
        .p2_up_btn (p2_up_btn),
        .p2_dn_btn (p2_dn_btn),
        .goal_p1   (goal_p1),
        .goal_p2   (goal_p2),
        .p1_up     (p1_up),
        .p1_down   (p1_down),
        .p2_up     (p2_up),
        .p2_down   (p2_down),
        .ball_rst  (ball_rst),
        .ball_en   (ball_en),
        .serve_dir (serve_dir),
        .p1_score  (p1_score),
        .p2_score  (p2_score),
        .gameover  (gameover),
        .winner    (winner),
        .state     (state)
    );

    always #5 clk = ~clk;

    // btn = {p1_up, p1_dn, p2_up, p2_dn}; goal = {goal_p1, goal_p2}
    // fl  = {ball_rst, ball_en, serve_dir, gameover, winner}
    // mv  = {p1_up, p1_down, p2_up, p2_down}
    typedef struct {
        logic       rst;
        logic       start;
        logic [3:0] btn;
        logic [1:0] goal;
        logic       tick;
        int         pad;
        logic [1:0] st;
        logic [3:0] s1;
        logic [3:0] s2;
        logic [4:0] fl;
        logic [3:0] mv;
    } vec_t;

    vec_t vq[$];

    task automatic v(input logic r, input logic s, input logic [3:0] b,
                     input logic [1:0] g, input logic t, input int pad,
                     input logic [1:0] st, input logic [3:0] s1,
                     input logic [3:0] s2, input logic [4:0] fl,
                     input logic [3:0] mv);
        vec_t x;
        x.rst = r; x.start = s; x.btn = b; x.goal = g; x.tick = t;
        x.pad = pad; x.st = st; x.s1 = s1; x.s2 = s2; x.fl = fl; x.mv = mv;
        vq.push_back(x);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [18:0] act,
                         input logic [18:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [18:0] outs();
        return {state, p1_score, p2_score,
                ball_rst, ball_en, serve_dir, gameover, winner,
                p1_up, p1_down, p2_up, p2_down};
    endfunction

    function automatic logic [18:0] moves();
        return {15'd0, p1_up, p1_down, p2_up, p2_down};
    endfunction

    initial begin
        // reset with start held, then no-edge start, then a real press
        v(1, 1, 4'b0000, 2'b00, 0, 1, 2'd0, 4'd0, 4'd0, 5'b10000, 4'b0000);
        v(0, 1, 4'b0000, 2'b00, 0, 2, 2'd0, 4'd0, 4'd0, 5'b10000, 4'b0000);
        v(0, 0, 4'b0000, 2'b00, 0, 1, 2'd0, 4'd0, 4'd0, 5'b10000, 4'b0000);
        v(0, 1, 4'b0000, 2'b00, 0, 0, 2'd1, 4'd0, 4'd0, 5'b10000, 4'b0000);
        // serve countdown: PLAY on the cycle after the 3rd tick
        v(0, 1, 4'b0000, 2'b00, 1, 9, 2'd1, 4'd0, 4'd0, 5'b10000, 4'b0000);
        v(0, 1, 4'b0000, 2'b00, 1, 9, 2'd1, 4'd0, 4'd0, 5'b10000, 4'b0000);
        v(0, 1, 4'b0000, 2'b00, 1, 0, 2'd2, 4'd0, 4'd0, 5'b01000, 4'b0000);
        // goal p1 -> 1:0, serve toward p2
        v(0, 1, 4'b0000, 2'b10, 0, 0, 2'd1, 4'd1, 4'd0, 5'b10100, 4'b0000);
        v(0, 1, 4'b0000, 2'b00, 1, 9, 2'd1, 4'd1, 4'd0, 5'b10100, 4'b0000);
        v(0, 1, 4'b0000, 2'b00, 1, 9, 2'd1, 4'd1, 4'd0, 5'b10100, 4'b0000);
        v(0, 1, 4'b0000, 2'b00, 1, 0, 2'd2, 4'd1, 4'd0, 5'b01100, 4'b0000);
        // goal p2 -> 1:1, then goal p2 during SERVE is ignored
        v(0, 1, 4'b0000, 2'b01, 0, 0, 2'd1, 4'd1, 4'd1, 5'b10000, 4'b0000);
        v(0, 1, 4'b0000, 2'b01, 0, 0, 2'd1, 4'd1, 4'd1, 5'b10000, 4'b0000);
        v(0, 1, 4'b0000, 2'b00, 1, 9, 2'd1, 4'd1, 4'd1, 5'b10000, 4'b0000);
        v(0, 1, 4'b0000, 2'b00, 1, 9, 2'd1, 4'd1, 4'd1, 5'b10000, 4'b0000);
        v(0, 1, 4'b0000, 2'b00, 1, 0, 2'd2, 4'd1, 4'd1, 5'b01000, 4'b0000);
        // both goals together: p1 wins the tie -> 2:1
        v(0, 1, 4'b0000, 2'b11, 0, 0, 2'd1, 4'd2, 4'd1, 5'b10100, 4'b0000);
        v(0, 1, 4'b0000, 2'b00, 1, 9, 2'd1, 4'd2, 4'd1, 5'b10100, 4'b0000);
        v(0, 1, 4'b0000, 2'b00, 1, 9, 2'd1, 4'd2, 4'd1, 5'b10100, 4'b0000);
        v(0, 1, 4'b0000, 2'b00, 1, 0, 2'd2, 4'd2, 4'd1, 5'b01100, 4'b0000);
        // p1 up held for 6 ticks, p2 both held: p1_up after ticks 1,3,5
        v(0, 1, 4'b1011, 2'b00, 0, 0, 2'd2, 4'd2, 4'd1, 5'b01100, 4'b0000);
        v(0, 1, 4'b1011, 2'b00, 1, 9, 2'd2, 4'd2, 4'd1, 5'b01100, 4'b1000);
        v(0, 1, 4'b1011, 2'b00, 1, 9, 2'd2, 4'd2, 4'd1, 5'b01100, 4'b0000);
        v(0, 1, 4'b1011, 2'b00, 1, 9, 2'd2, 4'd2, 4'd1, 5'b01100, 4'b1000);
        v(0, 1, 4'b1011, 2'b00, 1, 9, 2'd2, 4'd2, 4'd1, 5'b01100, 4'b0000);
        v(0, 1, 4'b1011, 2'b00, 1, 9, 2'd2, 4'd2, 4'd1, 5'b01100, 4'b1000);
        v(0, 1, 4'b1011, 2'b00, 1, 9, 2'd2, 4'd2, 4'd1, 5'b01100, 4'b0000);
        // reset mid-PLAY at 2:1
        v(1, 0, 4'b0000, 2'b00, 0, 0, 2'd0, 4'd0, 4'd0, 5'b10000, 4'b0000);
        v(0, 0, 4'b0000, 2'b00, 0, 0, 2'd0, 4'd0, 4'd0, 5'b10000, 4'b0000);
        v(0, 1, 4'b0000, 2'b00, 0, 0, 2'd1, 4'd0, 4'd0, 5'b10000, 4'b0000);
        // p1 scores three times -> OVER, winner p1
        v(0, 1, 4'b0000, 2'b00, 1, 9, 2'd1, 4'd0, 4'd0, 5'b10000, 4'b0000);
        v(0, 1, 4'b0000, 2'b00, 1, 9, 2'd1, 4'd0, 4'd0, 5'b10000, 4'b0000);
        v(0, 1, 4'b0000, 2'b00, 1, 0, 2'd2, 4'd0, 4'd0, 5'b01000, 4'b0000);
        v(0, 1, 4'b0000, 2'b10, 0, 0, 2'd1, 4'd1, 4'd0, 5'b10100, 4'b0000);
        v(0, 1, 4'b0000, 2'b00, 1, 9, 2'd1, 4'd1, 4'd0, 5'b10100, 4'b0000);
        v(0, 1, 4'b0000, 2'b00, 1, 9, 2'd1, 4'd1, 4'd0, 5'b10100, 4'b0000);
        v(0, 1, 4'b0000, 2'b00, 1, 0, 2'd2, 4'd1, 4'd0, 5'b01100, 4'b0000);
        v(0, 1, 4'b0000, 2'b10, 0, 0, 2'd1, 4'd2, 4'd0, 5'b10100, 4'b0000);
        v(0, 1, 4'b0000, 2'b00, 1, 9, 2'd1, 4'd2, 4'd0, 5'b10100, 4'b0000);
        v(0, 1, 4'b0000, 2'b00, 1, 9, 2'd1, 4'd2, 4'd0, 5'b10100, 4'b0000);
        v(0, 1, 4'b0000, 2'b00, 1, 0, 2'd2, 4'd2, 4'd0, 5'b01100, 4'b0000);
        v(0, 1, 4'b0000, 2'b10, 0, 0, 2'd3, 4'd3, 4'd0, 5'b00110, 4'b0000);
        // OVER: no pulses, goals ignored, scores held
        v(0, 1, 4'b1000, 2'b00, 1, 9, 2'd3, 4'd3, 4'd0, 5'b00110, 4'b0000);
        v(0, 1, 4'b1000, 2'b01, 1, 0, 2'd3, 4'd3, 4'd0, 5'b00110, 4'b0000);
        v(0, 0, 4'b0000, 2'b00, 0, 0, 2'd3, 4'd3, 4'd0, 5'b00110, 4'b0000);
        // start from OVER: scores and gameover cleared together
        v(0, 1, 4'b0000, 2'b00, 0, 0, 2'd1, 4'd0, 4'd0, 5'b10000, 4'b0000);
        v(0, 1, 4'b0000, 2'b00, 1, 9, 2'd1, 4'd0, 4'd0, 5'b10000, 4'b0000);
        v(0, 1, 4'b0000, 2'b00, 1, 9, 2'd1, 4'd0, 4'd0, 5'b10000, 4'b0000);
        v(0, 1, 4'b0000, 2'b00, 1, 0, 2'd2, 4'd0, 4'd0, 5'b01000, 4'b0000);
        // p2 scores three times -> OVER, winner p2
        v(0, 1, 4'b0000, 2'b01, 0, 0, 2'd1, 4'd0, 4'd1, 5'b10000, 4'b0000);
        v(0, 1, 4'b0000, 2'b00, 1, 9, 2'd1, 4'd0, 4'd1, 5'b10000, 4'b0000);
        v(0, 1, 4'b0000, 2'b00, 1, 9, 2'd1, 4'd0, 4'd1, 5'b10000, 4'b0000);
        v(0, 1, 4'b0000, 2'b00, 1, 0, 2'd2, 4'd0, 4'd1, 5'b01000, 4'b0000);
        v(0, 1, 4'b0000, 2'b01, 0, 0, 2'd1, 4'd0, 4'd2, 5'b10000, 4'b0000);
        v(0, 1, 4'b0000, 2'b00, 1, 9, 2'd1, 4'd0, 4'd2, 5'b10000, 4'b0000);
        v(0, 1, 4'b0000, 2'b00, 1, 9, 2'd1, 4'd0, 4'd2, 5'b10000, 4'b0000);
        v(0, 1, 4'b0000, 2'b00, 1, 0, 2'd2, 4'd0, 4'd2, 5'b01000, 4'b0000);
        v(0, 1, 4'b0000, 2'b01, 0, 0, 2'd3, 4'd0, 4'd3, 5'b00011, 4'b0000);

        foreach (vq[i]) begin
            rst        = vq[i].rst;
            start      = vq[i].start;
            {p1_up_btn, p1_dn_btn, p2_up_btn, p2_dn_btn} = vq[i].btn;
            {goal_p1, goal_p2} = vq[i].goal;
            frame_tick = vq[i].tick;
            cyc();
            check($sformatf("vec%0d", i), outs(),
                  {vq[i].st, vq[i].s1, vq[i].s2, vq[i].fl, vq[i].mv});
            goal_p1    = 1'b0;
            goal_p2    = 1'b0;
            frame_tick = 1'b0;
            for (int k = 0; k < vq[i].pad; k++) begin
                cyc();
                if (k == 0) check($sformatf("vec%0d_width", i), moves(), 19'd0);
            end
        end

        // restart from OVER (winner p2), then move-timer corner cases
        {p1_up_btn, p1_dn_btn, p2_up_btn, p2_dn_btn} = 4'b0000;
        start = 1'b0;
        cyc();
        start = 1'b1;
        cyc();
        check("restart", {11'd0, state, gameover, p1_score, p2_score},
              {11'd0, 2'd1, 1'b0, 4'd0, 4'd0});

        p1_dn_btn = 1'b1; frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        check("dn_first", moves(), 19'b0100);
        cyc();
        check("dn_width", moves(), 19'd0);

        // releasing clears the timer, so a fresh press moves on the next tick
        p1_dn_btn = 1'b0;
        cyc();
        p1_dn_btn = 1'b1; frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        check("dn_fresh", moves(), 19'b0100);

        // both held: no pulse and timer cleared
        p1_up_btn = 1'b1; p1_dn_btn = 1'b1;
        repeat (4) cyc();
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        check("p1_both", moves(), 19'd0);

        p1_dn_btn = 1'b0;
        repeat (4) cyc();
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        check("up_after_both", moves(), 19'b1000);
        check("play_after_ticks", {17'd0, state}, {17'd0, 2'd2});

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pong_match_ctrl.md
Name: pong_match_ctrl

Overview:
Match sequencer for the Pong design. Runs the match state machine (idle, serve, play, game over) and keeps both score counters. Drives the ball reset and enable controls and the gameover flag to both paddle blocks. Converts held paddle buttons into rate-limited one-cycle move pulses, which drive the paddle blocks' up/down inputs.

Parameters:
WIN_SCORE, 7, points needed to win; legal range 1..15.
SERVE_DELAY, 60, frame_tick pulses spent in SERVE before the ball is released; minimum 1.
MOVE_PERIOD, 4, minimum frame_ticks between successive move pulses for one player; minimum 1.

Ports:
clk  in  1  system clock
rst  in  1  reset
frame_tick  in  1  one-cycle pulse, once per video frame
start  in  1  start button, level, already synchronised
p1_up_btn, p1_dn_btn  in  1 each  player 1 buttons, level
p2_up_btn, p2_dn_btn  in  1 each  player 2 buttons, level
goal_p1  in  1  ball passed player 2 edge; point to player 1
goal_p2  in  1  ball passed player 1 edge; point to player 2
p1_up, p1_down, p2_up, p2_down  out  1 each  one-cycle move pulses to the paddle blocks
ball_rst  out  1  hold ball at centre
ball_en  out  1  ball motion enable
serve_dir  out  1  0 = serve toward player 1, 1 = toward player 2
p1_score, p2_score  out  4 each  current scores
gameover  out  1  to both paddle blocks' gameover_in
winner  out  1  0 = player 1, 1 = player 2; valid while gameover
state  out  2  IDLE=0, SERVE=1, PLAY=2, OVER=3; debug output

Behaviour:
- Reset: rst is synchronous and active-high; clock is clk. Reset has priority over everything and may occur in any state.
- Reset values: state=IDLE; scores=0; serve_dir=0; winner=0; gameover=0; ball_en=0; ball_rst=1; all move pulses 0; move timers 0; start_q=1.
- Start press: start_q is a registered copy of start. A press is start & ~start_q. Because start_q resets to 1, holding start through reset is not a press.
- Outputs are registered. Each output reflects its transition one cycle after the triggering cycle.
- IDLE: ball_rst=1, ball_en=0, gameover=0.
  - start press -> SERVE.
  - Entering SERVE: scores cleared, serve counter loaded with SERVE_DELAY.
- SERVE: ball_rst=1, ball_en=0.
  - Each frame_tick decrements the serve counter.
  - frame_tick while counter==1 -> PLAY.
  - Time in SERVE is exactly SERVE_DELAY ticks.
- PLAY: ball_rst=0, ball_en=1.
  - goal_p1: p1_score+1 and serve_dir=1.
  - goal_p2: p2_score+1 and serve_dir=0.
  - If both goals are asserted in the same cycle, goal_p1 wins and goal_p2 is dropped.
  - If the new score equals WIN_SCORE: -> OVER, winner set to the scorer.
  - Otherwise: -> SERVE with the counter reloaded.
  - Goals are ignored in every other state.
- OVER: gameover=1, ball_en=0, ball_rst=0 (ball frozen in place).
  - Scores are held.
  - start press -> SERVE: scores cleared, gameover=0 in the same update, serve_dir=0.
- Move pulses: one independent timer per player, 0..MOVE_PERIOD-1.
  - Active only in SERVE and PLAY. In IDLE and OVER, pulses are 0 and timers are cleared.
  - Exactly one button held, a frame_tick occurs, and the timer is 0: emit that direction's pulse for one cycle (the cycle after the frame_tick), and load the timer with MOVE_PERIOD-1.
  - Timer nonzero with a button held: decrement on each frame_tick.
  - Both buttons held, or neither held: no pulse, and the timer is cleared. A fresh press therefore moves on the next frame_tick.
  - Pulses are never asserted on two consecutive cycles.
  - p1_up and p1_down are never asserted together; the same holds for player 2.
- Scores never exceed WIN_SCORE. No wrap is possible within the legal parameter range.

Test Plan:
Run all scenarios with WIN_SCORE=3, SERVE_DELAY=3, MOVE_PERIOD=2, and frame_tick every 10 clk.
1. Reset, then hold start high with no edge -> state stays 0, ball_rst=1. Release start, then press -> state=1 one cycle later, scores 0.
2. In SERVE, count frame_ticks -> state=2 exactly on the cycle after the 3rd tick, with ball_en=1 and ball_rst=0 at the same time.
3. In PLAY, pulse goal_p1 -> p1_score=1, serve_dir=1, state=1. After 3 ticks state=2.
   - Repeat goal_p1 twice more -> state=3, gameover=1, winner=0, p1_score=3.
4. In PLAY, assert goal_p1 and goal_p2 in the same cycle -> p1_score+1, p2_score unchanged.
   - Assert goal_p2 while in SERVE -> no score change.
5. Hold p1_up_btn for 6 ticks in PLAY -> p1_up pulses after ticks 1, 3 and 5 only, each 1 cycle wide.
   - Hold both p2 buttons -> no p2 pulses.
   - In OVER, hold p1_up_btn -> no pulses.
6. Assert rst mid-PLAY with scores 2:1 -> next cycle state=0, scores 0:0, ball_rst=1, gameover=0.
   - Then press start from OVER -> state=1, scores 0, gameover=0.
